tagged_regfile: RTL and testbench

- Parametrised architectural register file for the out-of-order core. It generalises the single load-enable register to DEPTH entries.
- Each entry carries data, a busy bit and the ROB tag of its pending producer.
- Dispatch marks destinations busy. Commit writes results back and clears busy only on a tag match. Flush drops all renames.
- Sits between the decode/dispatch stage and the ROB commit port, and feeds operands and tags to the reservation stations.

---
 rtl/tagged_regfile.sv | 105 ++++++++++
 tb/tb_tagged_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tagged_regfile.sv
// Architectural register file with per-entry busy bit and producer ROB tag.
// Dispatch renames a destination, commit retires data and clears busy on a tag match.
module tagged_regfile #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  parameter  int TAG_W = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dispatch_en,
  input  logic [AW-1:0]    dispatch_reg,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             commit_en,
  input  logic [AW-1:0]    commit_reg,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [WIDTH-1:0] commit_data,
  input  logic             flush,
  input  logic [AW-1:0]    rd_a_idx,
  input  logic [AW-1:0]    rd_b_idx,
  output logic [WIDTH-1:0] rd_a_data,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_a_busy,
  output logic             rd_b_busy,
  output logic [TAG_W-1:0] rd_a_tag,
  output logic [TAG_W-1:0] rd_b_tag
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             commit_clears;

  // A commit only retires the rename if it comes from the youngest pending producer.
  assign commit_clears = commit_en && busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag);

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en) begin
      data_d[commit_reg] = commit_data;
      if (commit_clears) begin
        busy_d[commit_reg] = 1'b0;
      end
    end
    // Dispatch is applied after commit so a same-register rename stays pending.
    if (flush) begin
      busy_d = '0;
    end else if (dispatch_en) begin
      busy_d[dispatch_reg] = 1'b1;
      tag_d[dispatch_reg]  = dispatch_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  // Reads see the retiring value in the same cycle; gated so reset shows all zeros.
  always_comb begin
    rd_a_data = '0;
    rd_a_busy = 1'b0;
    rd_a_tag  = '0;
    rd_b_data = '0;
    rd_b_busy = 1'b0;
    rd_b_tag  = '0;
    if (rst_n) begin
      rd_a_data = data_q[rd_a_idx];
      rd_a_busy = busy_q[rd_a_idx];
      rd_a_tag  = tag_q[rd_a_idx];
      if (commit_en && (commit_reg == rd_a_idx)) begin
        rd_a_data = commit_data;
        if (commit_clears) begin
          rd_a_busy = 1'b0;
        end
      end
      rd_b_data = data_q[rd_b_idx];
      rd_b_busy = busy_q[rd_b_idx];
      rd_b_tag  = tag_q[rd_b_idx];
      if (commit_en && (commit_reg == rd_b_idx)) begin
        rd_b_data = commit_data;
        if (commit_clears) begin
          rd_b_busy = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tagged_regfile.sv
// Directed bench for tagged_regfile: reset behaviour, a cycle-by-cycle vector
// table for rename/commit/flush, and a hand sequence for reset mid-operation.
module tb_tagged_regfile;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dispatch_en;
  logic [AW-1:0]    dispatch_reg;
  logic [TAG_W-1:0] dispatch_tag;
  logic             commit_en;
  logic [AW-1:0]    commit_reg;
  logic [TAG_W-1:0] commit_tag;
  logic [WIDTH-1:0] commit_data;
  logic             flush;
  logic [AW-1:0]    rd_a_idx;
  logic [AW-1:0]    rd_b_idx;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_a_busy;
  logic             rd_b_busy;
  logic [TAG_W-1:0] rd_a_tag;
  logic [TAG_W-1:0] rd_b_tag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             dis_en;
    logic [AW-1:0]    dis_reg;
    logic [TAG_W-1:0] dis_tag;
    logic             com_en;
    logic [AW-1:0]    com_reg;
    logic [TAG_W-1:0] com_tag;
    logic [WIDTH-1:0] com_data;
    logic             fl;
    logic [AW-1:0]    a_idx;
    logic [AW-1:0]    b_idx;
    logic [WIDTH-1:0] a_data;
    logic             a_busy;
    logic [TAG_W-1:0] a_tag;
    logic [WIDTH-1:0] b_data;
    logic             b_busy;
    logic [TAG_W-1:0] b_tag;
  } vec_t;

  vec_t vecs[$];

  tagged_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_en(dispatch_en), .dispatch_reg(dispatch_reg), .dispatch_tag(dispatch_tag),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy),
    .rd_a_tag(rd_a_tag), .rd_b_tag(rd_b_tag)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic dis_en, input int dis_reg, input int dis_tag,
    input logic com_en, input int com_reg, input int com_tag, input int com_data,
    input logic fl, input int a_idx, input int b_idx,
    input int a_data, input logic a_busy, input int a_tag,
    input int b_data, input logic b_busy, input int b_tag);
    vec_t v;
    v.dis_en = dis_en;  v.dis_reg = AW'(dis_reg);  v.dis_tag = TAG_W'(dis_tag);
    v.com_en = com_en;  v.com_reg = AW'(com_reg);  v.com_tag = TAG_W'(com_tag);
    v.com_data = WIDTH'(com_data);
    v.fl = fl;  v.a_idx = AW'(a_idx);  v.b_idx = AW'(b_idx);
    v.a_data = WIDTH'(a_data);  v.a_busy = a_busy;  v.a_tag = TAG_W'(a_tag);
    v.b_data = WIDTH'(b_data);  v.b_busy = b_busy;  v.b_tag = TAG_W'(b_tag);
    return v;
  endfunction

  task automatic setIdle();
    dispatch_en = 1'b0; dispatch_reg = '0; dispatch_tag = '0;
    commit_en = 1'b0; commit_reg = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    dispatch_en = v.dis_en; dispatch_reg = v.dis_reg; dispatch_tag = v.dis_tag;
    commit_en = v.com_en; commit_reg = v.com_reg; commit_tag = v.com_tag;
    commit_data = v.com_data; flush = v.fl;
    rd_a_idx = v.a_idx; rd_b_idx = v.b_idx;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkPorts(input string name,
                            input logic [WIDTH-1:0] a_data, input logic a_busy, input logic [TAG_W-1:0] a_tag,
                            input logic [WIDTH-1:0] b_data, input logic b_busy, input logic [TAG_W-1:0] b_tag);
    checkOutput({name, " a_data"}, 32'(rd_a_data), 32'(a_data));
    checkOutput({name, " a_busy"}, 32'(rd_a_busy), 32'(a_busy));
    checkOutput({name, " a_tag"},  32'(rd_a_tag),  32'(a_tag));
    checkOutput({name, " b_data"}, 32'(rd_b_data), 32'(b_data));
    checkOutput({name, " b_busy"}, 32'(rd_b_busy), 32'(b_busy));
    checkOutput({name, " b_tag"},  32'(rd_b_tag),  32'(b_tag));
  endtask

  initial begin
    // Expected outputs are the combinational view during that cycle (state before the edge, plus commit bypass).
    //            dis     reg tag  com reg tag data    fl    a  b   a_data a_b a_t  b_data b_b b_t
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 3, 0, 'h0,    0, 0, 'h0,    0, 0));
    vecs.push_back(mk(1'b1, 3, 5, 1'b0, 0, 0, 'h0,    1'b0, 3, 3, 'h0,    0, 0, 'h0,    0, 0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 3, 3, 'h0,    1, 5, 'h0,    1, 5));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 3, 5, 'hBEEF, 1'b0, 3, 2, 'hBEEF, 0, 5, 'h0,    0, 0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 3, 3, 'hBEEF, 0, 5, 'hBEEF, 0, 5));
    vecs.push_back(mk(1'b1, 2, 1, 1'b0, 0, 0, 'h0,    1'b0, 2, 3, 'h0,    0, 0, 'hBEEF, 0, 5));
    vecs.push_back(mk(1'b1, 2, 4, 1'b0, 0, 0, 'h0,    1'b0, 2, 2, 'h0,    1, 1, 'h0,    1, 1));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 2, 1, 'h1234, 1'b0, 2, 2, 'h1234, 1, 4, 'h1234, 1, 4));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 2, 4, 'h5678, 1'b0, 2, 3, 'h5678, 0, 4, 'hBEEF, 0, 5));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 2, 2, 'h5678, 0, 4, 'h5678, 0, 4));
    vecs.push_back(mk(1'b1, 6, 2, 1'b0, 0, 0, 'h0,    1'b0, 6, 2, 'h0,    0, 0, 'h5678, 0, 4));
    vecs.push_back(mk(1'b1, 6, 7, 1'b1, 6, 2, 'h00AA, 1'b0, 6, 6, 'h00AA, 0, 2, 'h00AA, 0, 2));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 6, 6, 'h00AA, 1, 7, 'h00AA, 1, 7));
    vecs.push_back(mk(1'b1, 1, 1, 1'b0, 0, 0, 'h0,    1'b0, 1, 6, 'h0,    0, 0, 'h00AA, 1, 7));
    vecs.push_back(mk(1'b1, 4, 2, 1'b0, 0, 0, 'h0,    1'b0, 1, 4, 'h0,    1, 1, 'h0,    0, 0));
    vecs.push_back(mk(1'b1, 5, 6, 1'b0, 0, 0, 'h0,    1'b0, 4, 1, 'h0,    1, 2, 'h0,    1, 1));
    vecs.push_back(mk(1'b1, 0, 3, 1'b1, 4, 0, 'h0F0F, 1'b1, 4, 5, 'h0F0F, 1, 2, 'h0,    1, 6));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 4, 0, 'h0F0F, 0, 2, 'h0,    0, 0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 1, 5, 'h0,    0, 1, 'h0,    0, 6));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 6, 3, 'h00AA, 0, 7, 'hBEEF, 0, 5));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 7, 3, 'h1111, 1'b0, 7, 0, 'h1111, 0, 0, 'h0,    0, 0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0, 'h0,    1'b0, 7, 7, 'h1111, 0, 0, 'h1111, 0, 0));

    rst_n = 1'b0;
    setIdle();
    rd_a_idx = '0;
    rd_b_idx = '0;

    // Reset held with every input toggling: nothing may show or take effect.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      dispatch_en = 1'b1; dispatch_reg = AW'($urandom); dispatch_tag = TAG_W'($urandom);
      commit_en = 1'b1; commit_reg = AW'($urandom); commit_tag = TAG_W'($urandom);
      commit_data = WIDTH'($urandom) | 16'h0001; flush = c[0];
      rd_a_idx = commit_reg; rd_b_idx = AW'($urandom);
      #4;
      checkPorts($sformatf("reset c%0d", c), '0, 1'b0, '0, '0, 1'b0, '0);
    end

    @(negedge clk);
    setIdle();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_a_idx = AW'(i);
      rd_b_idx = AW'(DEPTH - 1 - i);
      #1;
      checkPorts($sformatf("post-reset r%0d", i), '0, 1'b0, '0, '0, 1'b0, '0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #4;
      checkPorts($sformatf("vec%0d", i), vecs[i].a_data, vecs[i].a_busy, vecs[i].a_tag,
                 vecs[i].b_data, vecs[i].b_busy, vecs[i].b_tag);
    end

    // Reset asserted mid-cycle while r7 is busy and its commit is on the port.
    @(negedge clk);
    setIdle();
    dispatch_en = 1'b1; dispatch_reg = 3'd7; dispatch_tag = 3'd5;
    rd_a_idx = 3'd7; rd_b_idx = 3'd7;
    @(negedge clk);
    setIdle();
    commit_en = 1'b1; commit_reg = 3'd7; commit_tag = 3'd5; commit_data = 16'hCAFE;
    #1;
    checkPorts("pre-reset r7", 16'hCAFE, 1'b0, 3'd5, 16'hCAFE, 1'b0, 3'd5);
    #1;
    rst_n = 1'b0;
    #1;
    checkPorts("async reset r7", '0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    checkPorts("reset edge r7", '0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    setIdle();
    rst_n = 1'b1;
    #4;
    checkPorts("after reset r7", '0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    rd_b_idx = 3'd3;
    #4;
    checkPorts("lost commit r7", '0, 1'b0, '0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
